// File: rtl/grf_sb_pkg.sv
// Shared sizing for the GRF issue scoreboard: register file geometry,
// pending-writer counter width and the widths of the status outputs.
package grf_sb_pkg;
    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int INFL_W  = 7;
    localparam int STALL_W = 32;
endpackage

// File: rtl/grf_sb_counter.sv
// Pending-writer count for one GRF register. Saturates at all-ones and
// refuses to drop below zero, flagging that case as an underflow.
module grf_sb_counter
    import grf_sb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    input  logic         flush,
    output logic [W-1:0] cnt,
    output logic         nonzero,
    output logic         full,
    output logic         underflow
);
    logic [W-1:0] cnt_q, cnt_d;

    assign cnt       = cnt_q;
    assign nonzero   = |cnt_q;
    assign full      = &cnt_q;
    // A same-cycle inc cancels the release, so only a lone release can underflow.
    assign underflow = dec & ~inc & ~nonzero;

    always_comb begin
        cnt_d = cnt_q;
        if (flush)
            cnt_d = '0;
        else if (inc && !dec && !full)
            cnt_d = cnt_q + W'(1);
        else if (dec && !inc && nonzero)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/grf_scoreboard.sv
// Issue-stage hazard controller for the GRF: tracks in-flight writers per
// register, holds issue on RAW hazards or counter saturation.
module grf_scoreboard
    import grf_sb_pkg::*;
#(
    parameter int NREG  = grf_sb_pkg::NREG,
    parameter int AW    = grf_sb_pkg::AW,
    parameter int CNT_W = grf_sb_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_rs,
    input  logic [AW-1:0]      iss_rt,
    input  logic               iss_use_rs,
    input  logic               iss_use_rt,
    input  logic               iss_wr_en,
    input  logic [AW-1:0]      iss_wa,
    output logic               iss_ready,
    input  logic               wb_valid,
    input  logic [AW-1:0]      wb_wa,
    input  logic               flush,
    output logic [INFL_W-1:0]  inflight,
    output logic [STALL_W-1:0] stall_cnt,
    output logic               err
);
    logic [NREG-1:0][CNT_W-1:0] pend;
    logic [NREG-1:0]            nz_v, full_v;
    logic [NREG-1:1]            inc_v, dec_v, uf_v;

    logic haz_rs, haz_rt, sat, fire, up, release_w, same_fire, down;

    logic [INFL_W-1:0]  inflight_q, inflight_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q, err_d;

    assign pend[0]   = '0;
    assign nz_v[0]   = 1'b0;
    assign full_v[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        assign inc_v[r] = up & (iss_wa == AW'(r));
        assign dec_v[r] = wb_valid & (wb_wa == AW'(r));
        grf_sb_counter #(.W(CNT_W)) u_cnt (
            .clk       (clk),
            .clr       (clr),
            .inc       (inc_v[r]),
            .dec       (dec_v[r]),
            .flush     (flush),
            .cnt       (pend[r]),
            .nonzero   (nz_v[r]),
            .full      (full_v[r]),
            .underflow (uf_v[r])
        );
    end

    // Only registered counts are consulted: the GRF has no bypass, so a
    // same-cycle writeback does not make its value visible to this reader.
    assign haz_rs    = iss_use_rs & (iss_rs != '0) & (pend[iss_rs] != '0);
    assign haz_rt    = iss_use_rt & (iss_rt != '0) & (pend[iss_rt] != '0);
    assign sat       = iss_wr_en & (iss_wa != '0) & full_v[iss_wa];
    assign iss_ready = ~haz_rs & ~haz_rt & ~sat;

    assign fire      = iss_valid & iss_ready;
    assign up        = fire & iss_wr_en & (iss_wa != '0);
    assign release_w = wb_valid & (wb_wa != '0);
    assign same_fire = up & (iss_wa == wb_wa);
    assign down      = release_w & (nz_v[wb_wa] | same_fire);

    always_comb begin
        inflight_d = inflight_q;
        if (flush)
            inflight_d = '0;
        else if (up && !down)
            inflight_d = inflight_q + INFL_W'(1);
        else if (down && !up)
            inflight_d = inflight_q - INFL_W'(1);

        stall_d = stall_q;
        if (iss_valid && !iss_ready && !(&stall_q))
            stall_d = stall_q + STALL_W'(1);

        err_d = err_q | (|uf_v);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            inflight_q <= '0;
            stall_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    assign inflight  = inflight_q;
    assign stall_cnt = stall_q;
    assign err       = err_q;
endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard: each step queues its expected ready,
// inflight, stall_cnt and err values, which are popped and checked as the DUT produces them.
module tb_grf_scoreboard;
    import grf_sb_pkg::*;

    logic               clk, clr;
    logic               iss_valid, iss_use_rs, iss_use_rt, iss_wr_en, iss_ready;
    logic [AW-1:0]      iss_rs, iss_rt, iss_wa, wb_wa;
    logic               wb_valid, flush, err;
    logic [INFL_W-1:0]  inflight;
    logic [STALL_W-1:0] stall_cnt;

    grf_scoreboard dut (
        .clk(clk), .clr(clr), .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
        .iss_use_rs(iss_use_rs), .iss_use_rt(iss_use_rt), .iss_wr_en(iss_wr_en),
        .iss_wa(iss_wa), .iss_ready(iss_ready), .wb_valid(wb_valid), .wb_wa(wb_wa),
        .flush(flush), .inflight(inflight), .stall_cnt(stall_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;   // 0 ready, 1 inflight, 2 stall_cnt, 3 err
        logic [31:0] exp;
    } sb_t;

    sb_t q_comb[$];
    sb_t q_reg[$];
    int  n_vec = 0;
    int  n_err = 0;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            0:       return {31'b0, iss_ready};
            1:       return {25'b0, inflight};
            2:       return stall_cnt;
            default: return {31'b0, err};
        endcase
    endfunction

    task automatic drain(input bit reg_phase);
        sb_t         e;
        logic [31:0] got;
        while ((reg_phase ? q_reg.size() : q_comb.size()) > 0) begin
            e   = reg_phase ? q_reg.pop_front() : q_comb.pop_front();
            got = observe(e.kind);
            n_vec++;
            assert (got === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, got, e.exp);
            end
        end
    endtask

    task automatic push_regs(input string tag, input int ei, input int es, input bit ee);
        q_reg.push_back('{{tag, " inflight"}, 1, 32'(ei)});
        q_reg.push_back('{{tag, " stall_cnt"}, 2, 32'(es)});
        q_reg.push_back('{{tag, " err"}, 3, {31'b0, ee}});
    endtask

    // One issue cycle: drive, check ready mid-cycle, check state after the edge.
    task automatic step(input int n, input bit v, input int rs, input bit urs,
                        input int rt, input bit urt, input bit wr, input int wa,
                        input bit wbv, input int wbwa, input bit fl,
                        input bit er, input int ei, input int es, input bit ee);
        string tag;
        tag        = $sformatf("step%0d", n);
        iss_valid  = v;
        iss_rs     = AW'(rs);
        iss_use_rs = urs;
        iss_rt     = AW'(rt);
        iss_use_rt = urt;
        iss_wr_en  = wr;
        iss_wa     = AW'(wa);
        wb_valid   = wbv;
        wb_wa      = AW'(wbwa);
        flush      = fl;
        q_comb.push_back('{{tag, " ready"}, 0, {31'b0, er}});
        push_regs(tag, ei, es, ee);
        #1 drain(1'b0);
        @(posedge clk);
        #1 drain(1'b1);
    endtask

    initial begin
        clr = 1'b1;
        iss_valid = 1'b1; iss_rs = 5'd8; iss_use_rs = 1'b1; iss_rt = '0; iss_use_rt = 1'b0;
        iss_wr_en = 1'b1; iss_wa = 5'd8; wb_valid = 1'b1; wb_wa = 5'd3; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        push_regs("reset", 0, 0, 1'b0);
        drain(1'b1);

        //   n  v rs urs rt urt wr wa wbv wbwa fl | rdy infl stall err
        step( 1, 1, 8, 1, 0, 0, 1, 8, 0, 0, 0,  1, 1, 0, 0);  // writer of $8
        step( 2, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0);  // reader of $8 stalls
        step( 3, 1, 8, 1, 0, 0, 0, 0, 1, 8, 0,  0, 0, 2, 0);  // release same cycle still stalls
        step( 4, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 2, 0);  // ready next cycle
        step( 5, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0,  1, 0, 2, 0);  // $0 never tracked
        step( 6, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0,  1, 0, 2, 0);  // release of $0 ignored
        step( 7, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  1, 1, 2, 0);
        step( 8, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  1, 2, 2, 0);
        step( 9, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  1, 3, 2, 0);
        step(10, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  0, 3, 3, 0);  // saturated
        step(11, 1, 0, 0, 0, 0, 1, 5, 1, 5, 0,  0, 2, 4, 0);
        step(12, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  1, 3, 4, 0);  // fourth writer fires
        step(13, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0,  0, 3, 4, 0);  // ready independent of valid
        step(14, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0,  1, 2, 4, 0);
        step(15, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0,  1, 1, 4, 0);
        step(16, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0,  1, 0, 4, 0);
        step(17, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0,  1, 1, 4, 0);
        step(18, 1, 0, 0, 0, 0, 1, 9, 1, 9, 0,  1, 1, 4, 0);  // fire+release net zero
        step(19, 1, 9, 1, 0, 0, 0, 0, 1, 9, 0,  0, 0, 5, 0);  // pend[9] still 1
        step(20, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5, 0);
        step(21, 1, 0, 0, 0, 0, 1,10, 1,10, 0,  1, 0, 5, 0);  // pend 0, no err
        step(22, 1,10, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5, 0);
        step(23, 0, 0, 0, 0, 0, 0, 0, 1,12, 0,  1, 0, 5, 1);  // empty release sets err
        step(24, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5, 1);
        step(25, 1, 0, 0,12, 1, 0, 0, 0, 0, 0,  1, 0, 5, 1);  // pend[12] still 0
        step(26, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0,  1, 1, 5, 1);
        step(27, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0,  1, 2, 5, 1);
        step(28, 1, 3, 0, 0, 0, 1, 4, 0, 0, 0,  1, 3, 5, 1);  // unused rs ignored
        step(29, 1, 0, 0, 0, 0, 1, 6, 1, 3, 1,  1, 0, 5, 1);  // flush wins
        step(30, 1, 3, 1, 4, 1, 0, 0, 0, 0, 0,  1, 0, 5, 1);
        step(31, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5, 1);  // flushed fire not counted
        step(32, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0,  1, 1, 5, 1);
        step(33, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 6, 1);  // stall counts during flush
        step(34, 1, 7, 1, 0, 0, 1, 7, 0, 0, 0,  1, 1, 6, 1);

        clr = 1'b1;
        iss_valid = 1'b1; iss_rs = 5'd7; iss_use_rs = 1'b1; iss_wr_en = 1'b0;
        @(posedge clk);
        #1 clr = 1'b0;
        push_regs("clr2", 0, 0, 1'b0);
        drain(1'b1);
        step(35, 1, 7, 1, 7, 1, 1, 7, 0, 0, 0,  1, 1, 0, 0);  // pre-reset writer forgotten
        step(36, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  1, 1, 0, 1);  // stale release flags err

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
